// File: rtl/lcd_show_string.sv
// String sequencer for the LCD character renderer.
// Walks a string held in a synchronous buffer, converts each byte to a glyph
// index, works out where the glyph goes (wrapping at the right edge, honouring
// newlines, stopping at the bottom edge) and hands one character at a time to
// the renderer, waiting for its completion pulse before moving on.
module lcd_show_string #(
    parameter int LCD_WIDTH  = 240,
    parameter int LCD_HEIGHT = 320,
    parameter int ADDR_W     = 6
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              show_str_flag,
    input  logic [ADDR_W:0]   str_len,
    input  logic [8:0]        x0,
    input  logic [8:0]        y0,
    input  logic              en_size,
    output logic [ADDR_W-1:0] str_addr,
    input  logic [7:0]        str_data,
    input  logic              show_char_done,
    output logic              show_char_flag,
    output logic [6:0]        ascii_num,
    output logic [8:0]        start_x,
    output logic [8:0]        start_y,
    output logic              char_size,
    output logic              busy,
    output logic              show_str_done,
    output logic              truncated
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // Panel limits widened so edge tests never wrap around.
    localparam logic [9:0]  LCD_W10 = 10'(LCD_WIDTH);
    localparam logic [9:0]  LCD_H10 = 10'(LCD_HEIGHT);
    localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [8:0]        x0_q, x0_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              size_q, size_d;
    logic [8:0]        cur_x_q, cur_x_d;
    logic [8:0]        cur_y_q, cur_y_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W-1:0] str_addr_q, str_addr_d;
    logic [6:0]        ascii_q, ascii_d;
    logic [8:0]        start_x_q, start_x_d;
    logic [8:0]        start_y_q, start_y_d;
    logic              flag_q, flag_d;
    logic              done_q, done_d;
    logic              trunc_q, trunc_d;

    logic [9:0]        cw, ch;
    logic [9:0]        x_end, y_end;

    // Glyph cell size for the latched font and where the current cell would end.
    always_comb begin
        cw    = size_q ? 10'd8  : 10'd6;
        ch    = size_q ? 10'd16 : 10'd12;
        x_end = {1'b0, cur_x_q} + cw;
        y_end = {1'b0, cur_y_q} + ch;
    end

    // Next-state logic: placement decisions, buffer fetch and renderer handshake.
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        len_d      = len_q;
        size_d     = size_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        idx_d      = idx_q;
        str_addr_d = str_addr_q;
        ascii_d    = ascii_q;
        start_x_d  = start_x_q;
        start_y_d  = start_y_q;
        flag_d     = 1'b0;
        done_d     = 1'b0;
        trunc_d    = trunc_q;

        case (state_q)
            S_IDLE: begin
                if (show_str_flag) begin
                    x0_d    = x0;
                    len_d   = str_len;
                    size_d  = en_size;
                    cur_x_d = x0;
                    cur_y_d = y0;
                    idx_d   = '0;
                    trunc_d = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (idx_q == len_q) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (y_end > LCD_H10) begin
                    trunc_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (x_end > LCD_W10) begin
                    if (cur_x_q == x0_q) begin
                        // The origin column itself cannot hold a glyph.
                        trunc_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        // Wrap to the next line; re-check it before drawing.
                        cur_x_d = x0_q;
                        cur_y_d = y_end[8:0];
                    end
                end else begin
                    str_addr_d = idx_q[ADDR_W-1:0];
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (str_data == 8'h0A) begin
                    cur_x_d = x0_q;
                    cur_y_d = y_end[8:0];
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_CHECK;
                end else begin
                    if (str_data >= 8'h20 && str_data <= 8'h7E) begin
                        ascii_d = 7'(str_data - 8'h20);
                    end else begin
                        ascii_d = 7'd0;
                    end
                    start_x_d = cur_x_q;
                    start_y_d = cur_y_q;
                    flag_d    = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (show_char_done) begin
                    cur_x_d = x_end[8:0];
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_CHECK;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            x0_q       <= '0;
            len_q      <= '0;
            size_q     <= 1'b0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            idx_q      <= '0;
            str_addr_q <= '0;
            ascii_q    <= '0;
            start_x_q  <= '0;
            start_y_q  <= '0;
            flag_q     <= 1'b0;
            done_q     <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            len_q      <= len_d;
            size_q     <= size_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            idx_q      <= idx_d;
            str_addr_q <= str_addr_d;
            ascii_q    <= ascii_d;
            start_x_q  <= start_x_d;
            start_y_q  <= start_y_d;
            flag_q     <= flag_d;
            done_q     <= done_d;
            trunc_q    <= trunc_d;
        end
    end

    assign str_addr       = str_addr_q;
    assign show_char_flag = flag_q;
    assign ascii_num      = ascii_q;
    assign start_x        = start_x_q;
    assign start_y        = start_y_q;
    assign char_size      = size_q;
    assign busy           = (state_q != S_IDLE);
    assign show_str_done  = done_q;
    assign truncated      = trunc_q;

endmodule
